// File: rtl/qu_res_station_if.sv
// Dispatch, CDB and issue signals of the reservation station grouped as one bundle.
// master drives requests/broadcasts (dispatch side), slave is the station itself.
interface qu_res_station_if #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned OP_WIDTH    = 13,
  parameter int unsigned VDATA_WIDTH = 32,
  parameter int unsigned ADATA_WIDTH = 12,
  parameter int unsigned TAG_WIDTH   = $clog2(DEPTH)
);
  logic                   flush;

  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [OP_WIDTH-1:0]    alloc_op;
  logic [VDATA_WIDTH-1:0] alloc_vj;
  logic [VDATA_WIDTH-1:0] alloc_vk;
  logic [TAG_WIDTH-1:0]   alloc_qj;
  logic [TAG_WIDTH-1:0]   alloc_qk;
  logic                   alloc_qj_pend;
  logic                   alloc_qk_pend;
  logic [ADATA_WIDTH-1:0] alloc_a;
  logic [TAG_WIDTH-1:0]   alloc_tag;

  logic                   cdb_valid;
  logic [TAG_WIDTH-1:0]   cdb_tag;
  logic [VDATA_WIDTH-1:0] cdb_data;

  logic                   issue_valid;
  logic                   issue_ready;
  logic [OP_WIDTH-1:0]    issue_op;
  logic [VDATA_WIDTH-1:0] issue_vj;
  logic [VDATA_WIDTH-1:0] issue_vk;
  logic [ADATA_WIDTH-1:0] issue_a;
  logic [TAG_WIDTH-1:0]   issue_tag;

  logic [TAG_WIDTH:0]     count;

  modport master (
    output flush,
    output alloc_valid, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk,
    output alloc_qj_pend, alloc_qk_pend, alloc_a,
    input  alloc_ready, alloc_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_a, issue_tag,
    input  count
  );

  modport slave (
    input  flush,
    input  alloc_valid, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk,
    input  alloc_qj_pend, alloc_qk_pend, alloc_a,
    output alloc_ready, alloc_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output issue_valid, issue_op, issue_vj, issue_vk, issue_a, issue_tag,
    output count
  );
endinterface

// File: rtl/qu_res_station.sv
// Reservation station array: allocates dispatched ops into the lowest free entry, wakes
// operands from the CDB by producer tag and issues the lowest-index ready entry.
module qu_res_station #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned OP_WIDTH    = 13,
  parameter int unsigned VDATA_WIDTH = 32,
  parameter int unsigned ADATA_WIDTH = 12,
  parameter int unsigned TAG_WIDTH   = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  qu_res_station_if.slave  bus
);

  localparam int unsigned CntW = TAG_WIDTH + 1;

  typedef struct packed {
    logic [OP_WIDTH-1:0]    op;
    logic [VDATA_WIDTH-1:0] vj;
    logic [VDATA_WIDTH-1:0] vk;
    logic [TAG_WIDTH-1:0]   qj;
    logic [TAG_WIDTH-1:0]   qk;
    logic [ADATA_WIDTH-1:0] a;
  } res_st_cell_t;

  res_st_cell_t         cell_q [DEPTH];
  res_st_cell_t         cell_d [DEPTH];
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     pj_q, pj_d;
  logic [DEPTH-1:0]     pk_q, pk_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [DEPTH-1:0]     ready;
  logic [TAG_WIDTH-1:0] free_idx;
  logic [TAG_WIDTH-1:0] ready_idx;
  logic                 alloc_ready;
  logic                 issue_valid;
  logic                 alloc_fire;
  logic                 issue_fire;
  logic                 byp_j;
  logic                 byp_k;

  assign ready       = busy_q & ~pj_q & ~pk_q;
  assign alloc_ready = ~&busy_q;
  assign issue_valid = |ready;
  assign alloc_fire  = bus.alloc_valid & alloc_ready;
  assign issue_fire  = issue_valid & bus.issue_ready;

  // Result arriving in the same cycle as a dispatch that waits on it.
  assign byp_j = bus.cdb_valid & bus.alloc_qj_pend & (bus.cdb_tag == bus.alloc_qj);
  assign byp_k = bus.cdb_valid & bus.alloc_qk_pend & (bus.cdb_tag == bus.alloc_qk);

  // Lowest-index priority encoders; both fall back to 0 when nothing qualifies.
  always_comb begin
    free_idx  = '0;
    ready_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = TAG_WIDTH'(i);
      if (ready[i])   ready_idx = TAG_WIDTH'(i);
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = free_idx;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_tag   = ready_idx;
  assign bus.issue_op    = cell_q[ready_idx].op;
  assign bus.issue_vj    = cell_q[ready_idx].vj;
  assign bus.issue_vk    = cell_q[ready_idx].vk;
  assign bus.issue_a     = cell_q[ready_idx].a;
  assign bus.count       = count_q;

  always_comb begin
    busy_d  = busy_q;
    pj_d    = pj_q;
    pk_d    = pk_q;
    count_d = count_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cell_d[i] = cell_q[i];
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (busy_q[i] && bus.cdb_valid) begin
        if (pj_q[i] && (cell_q[i].qj == bus.cdb_tag)) begin
          cell_d[i].vj = bus.cdb_data;
          pj_d[i]      = 1'b0;
        end
        if (pk_q[i] && (cell_q[i].qk == bus.cdb_tag)) begin
          cell_d[i].vk = bus.cdb_data;
          pk_d[i]      = 1'b0;
        end
      end
    end

    // The issued entry is busy and the allocated one is free, so they never collide.
    if (issue_fire) busy_d[ready_idx] = 1'b0;

    if (alloc_fire) begin
      busy_d[free_idx] = 1'b1;
      pj_d[free_idx]   = bus.alloc_qj_pend & ~byp_j;
      pk_d[free_idx]   = bus.alloc_qk_pend & ~byp_k;
      cell_d[free_idx] = '{
        op: bus.alloc_op,
        vj: byp_j ? bus.cdb_data : bus.alloc_vj,
        vk: byp_k ? bus.cdb_data : bus.alloc_vk,
        qj: bus.alloc_qj,
        qk: bus.alloc_qk,
        a:  bus.alloc_a
      };
    end

    count_d = count_q + CntW'(alloc_fire) - CntW'(issue_fire);

    if (bus.flush) begin
      busy_d  = '0;
      pj_d    = '0;
      pk_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      pj_q    <= '0;
      pk_q    <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      pj_q    <= pj_d;
      pk_q    <= pk_d;
      count_q <= count_d;
    end
  end

  // Payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      cell_q[i] <= cell_d[i];
    end
  end

endmodule

// File: tb/tb_qu_res_station.sv
// Self-checking bench for qu_res_station: directed scenarios plus randomized traffic,
// all checked every cycle against an entry-list reference model.
module tb_qu_res_station;

  localparam int unsigned DEPTH       = 32;
  localparam int unsigned OP_WIDTH    = 13;
  localparam int unsigned VDATA_WIDTH = 32;
  localparam int unsigned ADATA_WIDTH = 12;
  localparam int unsigned TAG_WIDTH   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qu_res_station_if #(
    .DEPTH(DEPTH), .OP_WIDTH(OP_WIDTH), .VDATA_WIDTH(VDATA_WIDTH),
    .ADATA_WIDTH(ADATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) bus ();

  qu_res_station #(
    .DEPTH(DEPTH), .OP_WIDTH(OP_WIDTH), .VDATA_WIDTH(VDATA_WIDTH),
    .ADATA_WIDTH(ADATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a flat list of entries, updated once per clock from the rules.
  typedef struct {
    bit                   busy;
    bit                   pj;
    bit                   pk;
    bit [OP_WIDTH-1:0]    op;
    bit [VDATA_WIDTH-1:0] vj;
    bit [VDATA_WIDTH-1:0] vk;
    bit [TAG_WIDTH-1:0]   qj;
    bit [TAG_WIDTH-1:0]   qk;
    bit [ADATA_WIDTH-1:0] a;
  } ent_t;

  ent_t m [DEPTH];
  int   m_count = 0;

  function automatic int lowest_free();
    for (int i = 0; i < int'(DEPTH); i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int lowest_ready();
    for (int i = 0; i < int'(DEPTH); i++) if (m[i].busy && !m[i].pj && !m[i].pk) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int f;
    int r;
    f = lowest_free();
    r = lowest_ready();
    check("alloc_ready", bus.alloc_ready, (f >= 0) ? 1 : 0);
    check("alloc_tag", bus.alloc_tag, (f >= 0) ? f : 0);
    check("issue_valid", bus.issue_valid, (r >= 0) ? 1 : 0);
    check("count", bus.count, m_count);
    if (r >= 0) begin
      check("issue_tag", bus.issue_tag, r);
      check("issue_op", bus.issue_op, m[r].op);
      check("issue_vj", bus.issue_vj, m[r].vj);
      check("issue_vk", bus.issue_vk, m[r].vk);
      check("issue_a", bus.issue_a, m[r].a);
    end
  endtask

  task automatic model_step();
    int  f;
    int  r;
    bit  fa;
    bit  fi;
    bit  hj;
    bit  hk;
    if (rst || bus.flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m[i].busy = 0;
        m[i].pj   = 0;
        m[i].pk   = 0;
      end
      m_count = 0;
      return;
    end
    f  = lowest_free();
    r  = lowest_ready();
    fa = bus.alloc_valid && (f >= 0);
    fi = bus.issue_ready && (r >= 0);
    if (bus.cdb_valid) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (m[i].busy && m[i].pj && m[i].qj == bus.cdb_tag) begin
          m[i].vj = bus.cdb_data;
          m[i].pj = 0;
        end
        if (m[i].busy && m[i].pk && m[i].qk == bus.cdb_tag) begin
          m[i].vk = bus.cdb_data;
          m[i].pk = 0;
        end
      end
    end
    if (fi) m[r].busy = 0;
    if (fa) begin
      hj = bus.alloc_qj_pend && bus.cdb_valid && (bus.cdb_tag == bus.alloc_qj);
      hk = bus.alloc_qk_pend && bus.cdb_valid && (bus.cdb_tag == bus.alloc_qk);
      m[f].busy = 1;
      m[f].op   = bus.alloc_op;
      m[f].qj   = bus.alloc_qj;
      m[f].qk   = bus.alloc_qk;
      m[f].a    = bus.alloc_a;
      m[f].pj   = bus.alloc_qj_pend && !hj;
      m[f].pk   = bus.alloc_qk_pend && !hk;
      m[f].vj   = hj ? bus.cdb_data : bus.alloc_vj;
      m[f].vk   = hk ? bus.cdb_data : bus.alloc_vk;
    end
    m_count = m_count + int'(fa) - int'(fi);
  endtask

  // One clock: check outputs of the current state, advance the model, cross the edge.
  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush         = 0;
    bus.alloc_valid   = 0;
    bus.alloc_op      = '0;
    bus.alloc_vj      = '0;
    bus.alloc_vk      = '0;
    bus.alloc_qj      = '0;
    bus.alloc_qk      = '0;
    bus.alloc_qj_pend = 0;
    bus.alloc_qk_pend = 0;
    bus.alloc_a       = '0;
    bus.cdb_valid     = 0;
    bus.cdb_tag       = '0;
    bus.cdb_data      = '0;
    bus.issue_ready   = 0;
  endtask

  task automatic alloc(input int op, input int vj, input int vk, input int qj, input bit pj,
                       input int qk, input bit pk);
    bus.alloc_valid   = 1;
    bus.alloc_op      = OP_WIDTH'(op);
    bus.alloc_vj      = VDATA_WIDTH'(vj);
    bus.alloc_vk      = VDATA_WIDTH'(vk);
    bus.alloc_qj      = TAG_WIDTH'(qj);
    bus.alloc_qk      = TAG_WIDTH'(qk);
    bus.alloc_qj_pend = pj;
    bus.alloc_qk_pend = pk;
    bus.alloc_a       = ADATA_WIDTH'(op + 1);
  endtask

  task automatic drain_flush();
    idle();
    bus.flush = 1;
    cycle();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    model_step();
    @(posedge clk);
    #1;
    rst = 0;

    // Reset state
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_alloc_tag", bus.alloc_tag, 0);
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_count", bus.count, 0);

    // Simple alloc then issue
    alloc(5, 3, 4, 0, 0, 0, 0);
    cycle();
    idle();
    check("t1_issue_valid", bus.issue_valid, 1);
    check("t1_issue_tag", bus.issue_tag, 0);
    check("t1_issue_vj", bus.issue_vj, 3);
    check("t1_issue_vk", bus.issue_vk, 4);
    bus.issue_ready = 1;
    cycle();
    idle();
    check("t1_count", bus.count, 0);

    // Wakeup from the CDB
    alloc(6, 0, 9, 7, 1, 0, 0);
    cycle();
    idle();
    cycle();
    cycle();
    check("t2_wait_valid", bus.issue_valid, 0);
    bus.cdb_valid = 1;
    bus.cdb_tag   = 7;
    bus.cdb_data  = 32'hDEAD;
    cycle();
    idle();
    check("t2_wake_valid", bus.issue_valid, 1);
    check("t2_wake_vj", bus.issue_vj, 32'hDEAD);
    drain_flush();

    // Same-cycle bypass on allocation
    alloc(7, 1, 0, 0, 0, 2, 1);
    bus.cdb_valid = 1;
    bus.cdb_tag   = 2;
    bus.cdb_data  = 32'h1234;
    cycle();
    idle();
    check("t3_byp_valid", bus.issue_valid, 1);
    check("t3_byp_vk", bus.issue_vk, 32'h1234);
    drain_flush();

    // Fill to full, then issue with a concurrent (blocked) alloc
    for (int i = 0; i < int'(DEPTH); i++) begin
      alloc(i, i * 3, i * 5, 0, 0, 0, 0);
      cycle();
    end
    idle();
    check("t4_full_count", bus.count, DEPTH);
    check("t4_full_ready", bus.alloc_ready, 0);
    check("t4_full_tag", bus.alloc_tag, 0);
    alloc(99, 1, 1, 0, 0, 0, 0);
    bus.issue_ready = 1;
    check("t4_full_ready_same", bus.alloc_ready, 0);
    cycle();
    idle();
    check("t4_after_ready", bus.alloc_ready, 1);
    check("t4_after_tag", bus.alloc_tag, 0);
    check("t4_after_count", bus.count, DEPTH - 1);
    drain_flush();

    // Issue order after entry 0 wakes
    alloc(10, 0, 0, 20, 1, 0, 0); cycle();
    alloc(11, 1, 1, 0, 0, 0, 0);  cycle();
    alloc(12, 0, 0, 21, 1, 0, 0); cycle();
    alloc(13, 3, 3, 0, 0, 0, 0);  cycle();
    idle();
    check("t5_pre_tag", bus.issue_tag, 1);
    bus.cdb_valid = 1;
    bus.cdb_tag   = 20;
    bus.cdb_data  = 32'h55;
    cycle();
    idle();
    bus.issue_ready = 1;
    check("t5_tag0", bus.issue_tag, 0);
    cycle();
    check("t5_tag1", bus.issue_tag, 1);
    cycle();
    check("t5_tag3", bus.issue_tag, 3);
    cycle();
    check("t5_empty_valid", bus.issue_valid, 0);
    drain_flush();

    // Flush, then reset, against a concurrent alloc and CDB hit
    for (int k = 0; k < 2; k++) begin
      alloc(20, 0, 0, 4, 1, 0, 0); cycle();
      alloc(21, 1, 2, 0, 0, 0, 0); cycle();
      alloc(22, 1, 2, 0, 0, 0, 0);
      bus.cdb_valid = 1;
      bus.cdb_tag   = 4;
      bus.cdb_data  = 32'hBEEF;
      if (k == 0) bus.flush = 1;
      else        rst = 1;
      cycle();
      rst = 0;
      idle();
      check(k == 0 ? "t6_flush_count" : "t6_rst_count", bus.count, 0);
      check(k == 0 ? "t6_flush_valid" : "t6_rst_valid", bus.issue_valid, 0);
      check(k == 0 ? "t6_flush_tag" : "t6_rst_tag", bus.alloc_tag, 0);
    end

    // Randomized traffic; issue_ready bias varies to sweep occupancy
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 1500; c++) begin
        bus.alloc_valid   = ($urandom_range(0, 3) != 0);
        bus.alloc_op      = OP_WIDTH'($urandom);
        bus.alloc_vj      = $urandom;
        bus.alloc_vk      = $urandom;
        bus.alloc_qj      = TAG_WIDTH'($urandom_range(0, 7));
        bus.alloc_qk      = TAG_WIDTH'($urandom_range(0, 7));
        bus.alloc_qj_pend = $urandom_range(0, 1) == 1;
        bus.alloc_qk_pend = $urandom_range(0, 1) == 1;
        bus.alloc_a       = ADATA_WIDTH'($urandom);
        bus.cdb_valid     = $urandom_range(0, 1) == 1;
        bus.cdb_tag       = TAG_WIDTH'($urandom_range(0, 7));
        bus.cdb_data      = $urandom;
        bus.issue_ready   = ($urandom_range(0, 3) < p);
        bus.flush         = ($urandom_range(0, 255) == 0);
        rst               = ($urandom_range(0, 511) == 0);
        cycle();
      end
    end
    rst = 0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
